// File: rtl/minn_var_delay_line.sv
// ============================================================================
// Module   : minn_var_delay_line
// Purpose  : Multi-lane circular-buffer delay line. The delay is counted in
//            accepted samples and is programmable at run time.
// Option   : MINN_VAR_DELAY_FILL_EN adds the fill_level and primed outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module minn_var_delay_line #(
  parameter int WIDTH         = 16,
  parameter int NUM_CH        = 2,
  parameter int MAX_DEPTH     = 64,
  parameter int DEFAULT_DELAY = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [NUM_CH*WIDTH-1:0]          in_data,
  input  logic                             cfg_load,
  input  logic [$clog2(MAX_DEPTH+1)-1:0]   delay_cfg,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   delay_q,
  output logic                             cfg_clamp,
`ifdef MINN_VAR_DELAY_FILL_EN
  output logic [$clog2(MAX_DEPTH+1)-1:0]   fill_level,
  output logic                             primed,
`endif
  output logic                             out_valid,
  output logic [NUM_CH*WIDTH-1:0]          out_data
);

  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int DW = NUM_CH * WIDTH;

  localparam logic [CW-1:0] c_FULL    = CW'(MAX_DEPTH);
  localparam logic [CW-1:0] c_ONE     = CW'(1);
  localparam logic [CW-1:0] c_DEFAULT = CW'(DEFAULT_DELAY);
  localparam logic [CW:0]   c_DEPTH_X = (CW+1)'(MAX_DEPTH);
  localparam logic [PW-1:0] c_LAST    = PW'(MAX_DEPTH - 1);

  logic [DW-1:0] r_mem [MAX_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_fill_cnt;
  logic [CW-1:0] r_delay_q;
  logic          r_cfg_clamp;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  logic [CW:0]   w_wr_ext;
  logic [CW:0]   w_dq_ext;
  logic [CW:0]   w_rd_ext;
  logic [PW-1:0] w_rd;
  logic [PW-1:0] w_wr_nxt;
  logic          w_cfg_lo;
  logic          w_cfg_hi;
  logic [CW-1:0] w_cfg_sat;
  logic          w_unused_rd;

  // Explicit wrap so non-power-of-two depths index correctly; D=MAX_DEPTH
  // lands on wr_ptr itself and reads the entry about to be overwritten.
  always_comb begin
    w_wr_ext = {{(CW+1-PW){1'b0}}, r_wr_ptr};
    w_dq_ext = {1'b0, r_delay_q};
    if (w_wr_ext >= w_dq_ext) begin
      w_rd_ext = w_wr_ext - w_dq_ext;
    end else begin
      w_rd_ext = w_wr_ext + c_DEPTH_X - w_dq_ext;
    end
  end

  assign w_rd        = w_rd_ext[PW-1:0];
  assign w_unused_rd = &{1'b0, w_rd_ext[CW:PW]};
  assign w_wr_nxt    = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PW'(1);

  assign w_cfg_lo  = (delay_cfg == '0);
  assign w_cfg_hi  = (delay_cfg > c_FULL);
  assign w_cfg_sat = w_cfg_lo ? c_ONE : (w_cfg_hi ? c_FULL : delay_cfg);

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_delay_q   <= c_DEFAULT;
      r_cfg_clamp <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_cfg_clamp <= cfg_load & (w_cfg_lo | w_cfg_hi);
      if (cfg_load) begin
        r_delay_q <= w_cfg_sat;
      end
      if (in_valid) begin
        r_wr_ptr   <= w_wr_nxt;
        r_out_data <= r_mem[w_rd];
      end
      // A sample accepted alongside a reload is the first of the new epoch.
      if (cfg_load) begin
        r_fill_cnt <= {{(CW-1){1'b0}}, in_valid};
      end else if (in_valid && (r_fill_cnt != c_FULL)) begin
        r_fill_cnt <= r_fill_cnt + c_ONE;
      end
      r_out_valid <= in_valid & ~cfg_load & (r_fill_cnt >= r_delay_q);
    end
  end

`ifdef MINN_VAR_DELAY_FILL_EN
  logic r_primed;

  // Updated on the same edge that first raises out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed <= 1'b0;
    end else if (cfg_load) begin
      r_primed <= 1'b0;
    end else if (in_valid) begin
      r_primed <= (r_fill_cnt >= r_delay_q);
    end
  end

  assign fill_level = r_fill_cnt;
  assign primed     = r_primed;
`endif

  assign delay_q   = r_delay_q;
  assign cfg_clamp = r_cfg_clamp;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire
